clock_set_ctrl: RTL and testbench
=================================

# clock_set_ctrl

Controller that sequences the 24-hour BCD clock counter. Generates the one-second advance strobe from the system clock and runs the time-set state machine: the user selects hours, then minutes, with two pushbutton pulses. On exit it loads the edited time, seconds cleared, into the counter. Sits between the debounced button logic and the 24-hour counter datapath.

## Interface
- TICK_DIV, default 50_000_000: clk cycles per second tick; legal range ≥ 2.
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- btn_mode  input  1  single-cycle pulse; advances the set-mode state.
- btn_inc  input  1  single-cycle pulse; increments the selected field.
- cur_hour_tens  input  2  current counter value, BCD.
- cur_hour_units  input  4  current counter value, BCD.
- cur_min_tens  input  4  current counter value, BCD.
- cur_min_units  input  4  current counter value, BCD.
- tick  output  1  one-cycle advance strobe to the counter.
- load  output  1  one-cycle strobe; counter takes the ld_* values.
- ld_hour_tens  output  2  BCD.
- ld_hour_units  output  4  BCD.
- ld_min_tens  output  4  BCD.
- ld_min_units  output  4  BCD.
- field_sel  output  2  00 = run, 01 = hours, 10 = minutes.

## Operation
- States: RUN, SET_HOUR, SET_MIN, COMMIT.
- RUN:
  - Prescaler counts 0..TICK_DIV-1 and wraps.
  - tick = 1 in the cycle the count equals TICK_DIV-1.
- RUN + btn_mode:
  - Capture cur_* into the edit registers.
  - Go to SET_HOUR.
  - Prescaler is forced to 0.
- SET_HOUR, SET_MIN:
  - Prescaler is held at 0; tick = 0.
  - The counter is frozen and does not advance.
- SET_HOUR + btn_inc: hour edit register increments in BCD.
  - Units wrap 9→0 with a carry into tens.
  - 23 → 00.
- SET_HOUR + btn_mode: go to SET_MIN.
- SET_MIN + btn_inc: minute edit register increments in BCD, 59 → 00.
- SET_MIN + btn_mode: go to COMMIT.
- COMMIT (exactly one cycle):
  - load = 1; ld_* = edit registers.
  - The counter clears seconds to 00 on load.
  - Next state RUN with the prescaler at 0.
- Simultaneous btn_mode and btn_inc: btn_mode wins and btn_inc is dropped.
- Pulses arriving during COMMIT are ignored.
- Invalid BCD captured from cur_* (e.g. hour 2x with units > 3): the first btn_inc on that field forces it to 00.
- ld_* hold their last committed value outside COMMIT.
- field_sel: RUN/COMMIT = 00, SET_HOUR = 01, SET_MIN = 10.

## Timing
- All outputs are registered.
- Reset values (reset = 0 sampled at a clk edge):
  - State RUN, prescaler 0, edit registers 0.
  - tick 0, load 0, ld_* 0, field_sel 00.
- Reset asserted mid-edit: aborts the edit with no load pulse; the counter keeps its previous time.
- First tick is TICK_DIV cycles after the first edge with reset = 1. Thereafter one tick every TICK_DIV cycles.
- Button response:
  - btn_mode sampled at edge N: state and field_sel change at N+1.
  - btn_inc sampled at edge N: edit register updated at N+1.
- The SET_MIN btn_mode at edge N: load high in cycle N+1 → N+2, state RUN from edge N+2.
- First tick after commit is TICK_DIV cycles after load deasserts.
- tick and load are never high in the same cycle.

## Structure
- Package clock_ctrl_pkg holds:
  - State enum (RUN, SET_HOUR, SET_MIN, COMMIT).
  - field_sel encodings.
  - BCD limit constants: HOUR_MAX_TENS = 2, HOUR_MAX_UNITS_AT_2 = 3, MIN_MAX_TENS = 5, BCD_MAX = 9.
- One sub-module: tick_prescaler, parameterised by TICK_DIV. It has inputs clk, reset, hold and output tick. Its counter width is $clog2(TICK_DIV).
- The FSM and the BCD edit incrementers stay in clock_set_ctrl.

## Test plan
All scenarios use TICK_DIV = 4.
- Reset then free run: tick pulses at cycles 4, 8, 12 after reset release; load stays 0 and field_sel stays 00.
- Hour wrap: cur time 22:15, then btn_mode and two btn_inc → hour edit goes 23 then 00. Then btn_mode, btn_mode → one-cycle load with ld = 00:15.
- Minute wrap and carry: capture 07:58, then btn_mode, btn_mode, btn_inc ×3 → minutes 59, 00, 01. Then btn_mode → load with 07:01; no tick during the edit.
- Simultaneous buttons: btn_mode and btn_inc in the same cycle in SET_HOUR → state goes to SET_MIN and the hour value is unchanged.
- Reset mid-edit: in SET_MIN with edit 12:34, pull reset low for one cycle → field_sel 00, no load pulse, ticks resume 4 cycles after release.
- Post-commit spacing: after load deasserts, the first tick comes exactly 4 cycles later and never coincides with load.

Source files
------------

// File: rtl/clock_ctrl_pkg.sv
// Shared types and constants for the clock time-set controller.
// BCD limits are used by the hour/minute edit incrementers.
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    COMMIT   = 2'd3
  } state_t;

  localparam logic [1:0] SEL_RUN  = 2'b00;
  localparam logic [1:0] SEL_HOUR = 2'b01;
  localparam logic [1:0] SEL_MIN  = 2'b10;

  localparam logic [1:0] HOUR_MAX_TENS       = 2'd2;
  localparam logic [3:0] HOUR_MAX_UNITS_AT_2 = 4'd3;
  localparam logic [3:0] MIN_MAX_TENS        = 4'd5;
  localparam logic [3:0] BCD_MAX             = 4'd9;

endpackage

// File: rtl/tick_prescaler.sv
// One-second strobe generator: counts 0..TICK_DIV-1 and pulses tick on wrap.
// hold clears the count and suppresses tick.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic hold,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             armed;

  // The first edge after reset leaves the count at 0, so the first tick lands
  // TICK_DIV cycles after that edge, matching the spacing after a hold.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt   <= '0;
      tick  <= 1'b0;
      armed <= 1'b0;
    end else if (hold || !armed) begin
      cnt   <= '0;
      tick  <= 1'b0;
      armed <= 1'b1;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CNT_W'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-set controller for the 24-hour BCD counter: second tick generation,
// hour/minute edit state machine and one-cycle load of the edited time.
module clock_set_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [1:0] cur_hour_tens,
  input  logic [3:0] cur_hour_units,
  input  logic [3:0] cur_min_tens,
  input  logic [3:0] cur_min_units,
  output logic       tick,
  output logic       load,
  output logic [1:0] ld_hour_tens,
  output logic [3:0] ld_hour_units,
  output logic [3:0] ld_min_tens,
  output logic [3:0] ld_min_units,
  output logic [1:0] field_sel
);

  state_t     state, state_next;
  logic [5:0] edit_hour, hour_next;
  logic [7:0] edit_min, min_next;
  logic [1:0] sel_next;
  logic       hold;

  // Invalid captured values (and 23) roll to 00.
  function automatic logic [5:0] hour_inc(input logic [5:0] h);
    logic [5:0] r;
    if (h[5:4] > HOUR_MAX_TENS || h[3:0] > BCD_MAX ||
        (h[5:4] == HOUR_MAX_TENS && h[3:0] >= HOUR_MAX_UNITS_AT_2))
      r = '0;
    else if (h[3:0] == BCD_MAX)
      r = {h[5:4] + 2'd1, 4'd0};
    else
      r = {h[5:4], h[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [7:0] min_inc(input logic [7:0] m);
    logic [7:0] r;
    if (m[7:4] > MIN_MAX_TENS || m[3:0] > BCD_MAX ||
        (m[7:4] == MIN_MAX_TENS && m[3:0] == BCD_MAX))
      r = '0;
    else if (m[3:0] == BCD_MAX)
      r = {m[7:4] + 4'd1, 4'd0};
    else
      r = {m[7:4], m[3:0] + 4'd1};
    return r;
  endfunction

  assign hold = (state != RUN) || btn_mode;

  always_comb begin
    state_next = state;
    hour_next  = edit_hour;
    min_next   = edit_min;
    case (state)
      RUN: if (btn_mode) begin
        state_next = SET_HOUR;
        hour_next  = {cur_hour_tens, cur_hour_units};
        min_next   = {cur_min_tens, cur_min_units};
      end
      SET_HOUR: begin
        if (btn_mode)     state_next = SET_MIN;
        else if (btn_inc) hour_next  = hour_inc(edit_hour);
      end
      SET_MIN: begin
        if (btn_mode)     state_next = COMMIT;
        else if (btn_inc) min_next   = min_inc(edit_min);
      end
      default: state_next = RUN;
    endcase

    case (state_next)
      SET_HOUR: sel_next = SEL_HOUR;
      SET_MIN:  sel_next = SEL_MIN;
      default:  sel_next = SEL_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= RUN;
      edit_hour <= '0;
      edit_min  <= '0;
      load      <= 1'b0;
      field_sel <= SEL_RUN;
      {ld_hour_tens, ld_hour_units, ld_min_tens, ld_min_units} <= '0;
    end else begin
      state     <= state_next;
      edit_hour <= hour_next;
      edit_min  <= min_next;
      load      <= (state_next == COMMIT);
      field_sel <= sel_next;
      if (state_next == COMMIT)
        {ld_hour_tens, ld_hour_units, ld_min_tens, ld_min_units} <= {edit_hour, edit_min};
    end
  end

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .hold (hold),
    .tick (tick)
  );

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl with TICK_DIV = 4.
module tb_clock_set_ctrl;

  localparam int unsigned DIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [1:0] cur_hour_tens = '0;
  logic [3:0] cur_hour_units = '0;
  logic [3:0] cur_min_tens = '0;
  logic [3:0] cur_min_units = '0;
  logic       tick, load;
  logic [1:0] ld_hour_tens, field_sel;
  logic [3:0] ld_hour_units, ld_min_tens, ld_min_units;

  clock_set_ctrl #(.TICK_DIV(DIV)) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_mode      (btn_mode),
    .btn_inc       (btn_inc),
    .cur_hour_tens (cur_hour_tens),
    .cur_hour_units(cur_hour_units),
    .cur_min_tens  (cur_min_tens),
    .cur_min_units (cur_min_units),
    .tick          (tick),
    .load          (load),
    .ld_hour_tens  (ld_hour_tens),
    .ld_hour_units (ld_hour_units),
    .ld_min_tens   (ld_min_tens),
    .ld_min_units  (ld_min_units),
    .field_sel     (field_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        mode;
    logic        inc;
    logic [13:0] cur;
    logic        tick;
    logic        load;
    logic [1:0]  sel;
    logic [13:0] ld;
  } vec_t;

  typedef struct packed {
    logic        tick;
    logic        load;
    logic [1:0]  sel;
    logic [13:0] ld;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [13:0] hm(input int h, input int m);
    return {2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  function automatic vec_t v(input logic r, input logic m, input logic i,
                             input logic [13:0] cur, input logic t, input logic l,
                             input logic [1:0] s, input logic [13:0] ld);
    vec_t x;
    x.rst = r; x.mode = m; x.inc = i; x.cur = cur;
    x.tick = t; x.load = l; x.sel = s; x.ld = ld;
    return x;
  endfunction

  task automatic apply(input vec_t x, input string tag);
    exp_t e, got;
    reset    = x.rst;
    btn_mode = x.mode;
    btn_inc  = x.inc;
    {cur_hour_tens, cur_hour_units, cur_min_tens, cur_min_units} = x.cur;
    e.tick = x.tick; e.load = x.load; e.sel = x.sel; e.ld = x.ld;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = {tick, load, field_sel, ld_hour_tens, ld_hour_units, ld_min_tens, ld_min_units};
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: no expected entry queued", tag);
    end else begin
      e = sb.pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL %s: got tick=%b load=%b sel=%b ld=%0d%0d:%0d%0d required tick=%b load=%b sel=%b ld=%0d%0d:%0d%0d",
                 tag, got.tick, got.load, got.sel, got.ld[13:12], got.ld[11:8], got.ld[7:4], got.ld[3:0],
                 e.tick, e.load, e.sel, e.ld[13:12], e.ld[11:8], e.ld[7:4], e.ld[3:0]);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [13:0] a, b, c, d, e5, z;
    a  = hm(22, 15);
    b  = hm(7, 58);
    c  = hm(9, 30);
    d  = {2'd2, 4'd5, 4'd6, 4'd1};
    e5 = hm(12, 34);
    z  = '0;

    // reset, free run (ticks at edges 4, 8, 12 after release), hour wrap, commit spacing
    tbl.push_back(v(0, 0, 0, a, 0, 0, 2'b00, z));
    tbl.push_back(v(0, 0, 0, a, 0, 0, 2'b00, z));
    for (int k = 0; k <= 12; k++)
      tbl.push_back(v(1, 0, 0, a, (k == 4 || k == 8 || k == 12), 0, 2'b00, z));
    tbl.push_back(v(1, 1, 0, a, 0, 0, 2'b01, z));
    tbl.push_back(v(1, 0, 1, a, 0, 0, 2'b01, z));
    tbl.push_back(v(1, 0, 1, a, 0, 0, 2'b01, z));
    tbl.push_back(v(1, 1, 0, a, 0, 0, 2'b10, z));
    tbl.push_back(v(1, 1, 0, a, 0, 1, 2'b00, hm(0, 15)));
    tbl.push_back(v(1, 0, 0, a, 0, 0, 2'b00, hm(0, 15)));
    for (int k = 1; k <= 4; k++)
      tbl.push_back(v(1, 0, 0, a, (k == 4), 0, 2'b00, hm(0, 15)));
    // minute wrap and carry, no tick while editing
    tbl.push_back(v(1, 1, 0, b, 0, 0, 2'b01, hm(0, 15)));
    tbl.push_back(v(1, 1, 0, b, 0, 0, 2'b10, hm(0, 15)));
    for (int k = 0; k < 3; k++) tbl.push_back(v(1, 0, 1, b, 0, 0, 2'b10, hm(0, 15)));
    for (int k = 0; k < 5; k++) tbl.push_back(v(1, 0, 0, b, 0, 0, 2'b10, hm(0, 15)));
    tbl.push_back(v(1, 1, 0, b, 0, 1, 2'b00, hm(7, 1)));
    tbl.push_back(v(1, 0, 0, b, 0, 0, 2'b00, hm(7, 1)));

    foreach (tbl[i]) apply(tbl[i], $sformatf("table[%0d]", i));

    // simultaneous buttons in SET_HOUR; pulses during COMMIT ignored
    apply(v(1, 1, 0, c, 0, 0, 2'b01, hm(7, 1)), "simul_enter");
    apply(v(1, 1, 1, c, 0, 0, 2'b10, hm(7, 1)), "simul_both");
    apply(v(1, 1, 0, c, 0, 1, 2'b00, hm(9, 30)), "simul_commit");
    apply(v(1, 1, 1, c, 0, 0, 2'b00, hm(9, 30)), "commit_ignore");
    for (int k = 1; k <= 4; k++)
      apply(v(1, 0, 0, c, (k == 4), 0, 2'b00, hm(9, 30)), $sformatf("post_commit[%0d]", k));

    // reset mid-edit aborts without load
    apply(v(1, 1, 0, e5, 0, 0, 2'b01, hm(9, 30)), "abort_hour");
    apply(v(1, 1, 0, e5, 0, 0, 2'b10, hm(9, 30)), "abort_min");
    apply(v(0, 0, 0, e5, 0, 0, 2'b00, z), "abort_reset");
    for (int k = 0; k <= 4; k++)
      apply(v(1, 0, 0, e5, (k == 4), 0, 2'b00, z), $sformatf("abort_resume[%0d]", k));

    // invalid captured BCD forced to 00 by first increment
    apply(v(1, 1, 0, d, 0, 0, 2'b01, z), "bad_enter");
    apply(v(1, 0, 1, d, 0, 0, 2'b01, z), "bad_hour_inc");
    apply(v(1, 1, 0, d, 0, 0, 2'b10, z), "bad_to_min");
    apply(v(1, 0, 1, d, 0, 0, 2'b10, z), "bad_min_inc");
    apply(v(1, 0, 1, d, 0, 0, 2'b10, z), "bad_min_inc2");
    apply(v(1, 1, 0, d, 0, 1, 2'b00, hm(0, 1)), "bad_commit");
    apply(v(1, 0, 0, d, 0, 0, 2'b00, hm(0, 1)), "bad_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
